// File: rtl/ris_frame_pkg.sv
// Shared state encoding and default geometry for the RIS frame streamer.
package ris_frame_pkg;
  localparam int RIS_ADDR_W       = 8;
  localparam int RIS_DATA_W       = 32;
  localparam int RIS_FRAME_WORDS  = 256;
  localparam int RIS_SCLK_DIV     = 4;
  localparam int RIS_LATCH_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } ris_state_e;
endpackage

// File: rtl/ris_frame_streamer_serializer.sv
// ris_bit_serializer: one word shifted MSB-first onto ris_sdo with a divided ris_sclk.
module ris_bit_serializer
  import ris_frame_pkg::*;
#(
  parameter int DATA_W   = RIS_DATA_W,
  parameter int SCLK_DIV = RIS_SCLK_DIV
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] ld_data,
  output logic              bit_done,
  output logic              word_done,
  output logic              ris_sclk,
  output logic              ris_sdo
);
  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bcnt;
  logic              phase_end;

  assign phase_end = (cnt == CNT_W'(SCLK_DIV - 1));
  assign bit_done  = en && ris_sclk && phase_end;
  assign word_done = bit_done && (bcnt == BIT_W'(DATA_W - 1));
  assign ris_sdo   = shreg[DATA_W-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      shreg    <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      ris_sclk <= 1'b0;
    end else if (load) begin
      shreg    <= ld_data;
      cnt      <= '0;
      bcnt     <= '0;
      ris_sclk <= 1'b0;
    end else if (en) begin
      if (phase_end) begin
        cnt      <= '0;
        ris_sclk <= ~ris_sclk;
        // data advances only at the end of the high phase; zero-fill leaves sdo low afterwards
        if (ris_sclk) begin
          shreg <= {shreg[DATA_W-2:0], 1'b0};
          bcnt  <= bcnt + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ris_frame_streamer.sv
// Streams a frame from the frame buffer onto the RIS chain, then latches it.
// Optional frame_xor checksum port when RIS_FRAME_XOR_EN is defined.
module ris_frame_streamer
  import ris_frame_pkg::*;
#(
  parameter int ADDR_W       = RIS_ADDR_W,
  parameter int DATA_W       = RIS_DATA_W,
  parameter int FRAME_WORDS  = RIS_FRAME_WORDS,
  parameter int SCLK_DIV     = RIS_SCLK_DIV,
  parameter int LATCH_CYCLES = RIS_LATCH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en_b,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] rdata_b,
  output logic              ris_sclk,
  output logic              ris_sdo,
  output logic              ris_latch,
  output logic              busy,
`ifdef RIS_FRAME_XOR_EN
  output logic [DATA_W-1:0] frame_xor,
`endif
  output logic              done
);
  localparam int WCNT_W = ADDR_W + 1;
  localparam int LAT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  ris_state_e        state, nxt;
  logic [ADDR_W-1:0] addr, addr_hold;
  logic [WCNT_W-1:0] word_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              ser_load, ser_en, ser_clr, bit_done, word_done;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start && !abort) nxt = S_FETCH;
      S_FETCH: nxt = S_CAPT;
      S_CAPT:  nxt = S_SHIFT;
      S_SHIFT: if (bit_done && word_done)
                 nxt = (word_cnt == WCNT_W'(FRAME_WORDS)) ? S_LATCH : S_FETCH;
      S_LATCH: if (lat_cnt == LAT_W'(LATCH_CYCLES - 1)) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (state != S_IDLE && abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      addr_hold <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start && !abort) begin
        addr     <= base_addr;
        word_cnt <= '0;
      end
      if (state == S_FETCH) addr_hold <= addr;
      if (state == S_CAPT && !abort) begin
        addr     <= addr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      lat_cnt <= (state == S_LATCH) ? lat_cnt + 1'b1 : '0;
    end
  end

`ifdef RIS_FRAME_XOR_EN
  always_ff @(posedge clk) begin
    if (rst)                                        frame_xor <= '0;
    else if (state == S_IDLE && start && !abort)    frame_xor <= '0;
    else if (state == S_CAPT && !abort)             frame_xor <= frame_xor ^ rdata_b;
  end
`endif

  // addr_b shows the live address only while fetching so it holds the last read when idle
  assign rd_en_b   = (state == S_FETCH);
  assign addr_b    = rd_en_b ? addr : addr_hold;
  assign ris_latch = (state == S_LATCH);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  assign ser_load = (state == S_CAPT) && !abort;
  assign ser_en   = (state == S_SHIFT) && !abort;
  assign ser_clr  = rst || abort || (state == S_IDLE);

  ris_bit_serializer #(.DATA_W(DATA_W), .SCLK_DIV(SCLK_DIV)) u_ser (
    .clk       (clk),
    .clr       (ser_clr),
    .load      (ser_load),
    .en        (ser_en),
    .ld_data   (rdata_b),
    .bit_done  (bit_done),
    .word_done (word_done),
    .ris_sclk  (ris_sclk),
    .ris_sdo   (ris_sdo)
  );
endmodule

// File: tb/tb_ris_frame_streamer.sv
// Directed bench for ris_frame_streamer with a cycle-numbered frame model.
module tb_ris_frame_streamer;
  localparam int AW = 8, DW = 32, FW = 4, SD = 1, LC = 2;
  localparam int WORD_C = 2 + 2 * DW * SD;
  localparam int DONE_C = FW * WORD_C + LC + 1;

  logic          clk = 0, rst = 1, start = 0, abort = 0;
  logic [AW-1:0] base_addr = '0, addr_b;
  logic [DW-1:0] rdata_b = '0;
  logic          rd_en_b, ris_sclk, ris_sdo, ris_latch, busy, done;
`ifdef RIS_FRAME_XOR_EN
  logic [DW-1:0] frame_xor;
`endif

  ris_frame_streamer #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .SCLK_DIV(SD),
                       .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .rd_en_b(rd_en_b), .addr_b(addr_b), .rdata_b(rdata_b), .ris_sclk(ris_sclk),
    .ris_sdo(ris_sdo), .ris_latch(ris_latch), .busy(busy),
`ifdef RIS_FRAME_XOR_EN
    .frame_xor(frame_xor),
`endif
    .done(done));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) if (rd_en_b) rdata_b <= mem[addr_b];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // model: frame is a numbered sequence of cycles since start acceptance
  bit            m_act = 0, chk_en = 0;
  int            m_c = 0;
  logic [AW-1:0] m_base = '0;
  logic [DW-1:0] m_xor = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_xor = '0;
    end else if (m_act) begin
      if (abort || m_c == DONE_C) m_act = 0;
      else m_c++;
    end else if (start && !abort) begin
      m_act = 1; m_c = 1; m_base = base_addr; m_xor = '0;
      for (int i = 0; i < FW; i++) m_xor ^= mem[8'(base_addr + 8'(i))];
    end
  end

  bit   prev_sclk = 0;
  bit   bits[$];
  always @(negedge clk) if (chk_en) begin
    logic e_rd, e_sclk, e_sdo, e_lat, e_busy, e_done;
    logic [AW-1:0] wa;
    {e_rd, e_sclk, e_sdo, e_lat, e_busy, e_done} = '0;
    wa = '0;
    if (m_act) begin
      e_busy = 1;
      if (m_c <= FW * WORD_C) begin
        int w, off, s;
        w   = (m_c - 1) / WORD_C;
        off = (m_c - 1) % WORD_C;
        wa  = m_base + 8'(w);
        if (off == 0) e_rd = 1;
        if (off >= 2) begin
          s = off - 2;
          e_sclk = ((s / SD) % 2) == 1;
          e_sdo  = mem[wa][DW - 1 - s / (2 * SD)];
        end
      end else if (m_c <= FW * WORD_C + LC) e_lat = 1;
      else e_done = 1;
    end
    chk("rd_en_b", 32'(rd_en_b), 32'(e_rd));
    chk("ris_sclk", 32'(ris_sclk), 32'(e_sclk));
    chk("ris_sdo", 32'(ris_sdo), 32'(e_sdo));
    chk("ris_latch", 32'(ris_latch), 32'(e_lat));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (e_rd) chk("addr_b", 32'(addr_b), 32'(wa));
`ifdef RIS_FRAME_XOR_EN
    if (e_done) chk("frame_xor_model", frame_xor, m_xor);
`endif
    if (ris_sclk && !prev_sclk) bits.push_back(ris_sdo);
    prev_sclk = ris_sclk;
  end

  int done_n, done_cnt, lat_n;
  int rd_q[$];
  logic [AW-1:0] ad_q[$];

  task automatic run(input logic [AW-1:0] b, input int re1, input int re2, input int ab);
    @(negedge clk); base_addr = b; start = 1;
    @(negedge clk); start = 0;
    done_n = -1; done_cnt = 0; lat_n = 0;
    rd_q.delete(); ad_q.delete(); bits.delete();
    for (int n = 1; n <= DONE_C + 30; n++) begin
      if (rd_en_b) begin rd_q.push_back(n); ad_q.push_back(addr_b); end
      if (ris_latch) lat_n++;
      if (done) begin done_n = n; done_cnt++; end
      start = (n == re1 || n == re2);
      abort = (n == ab);
      @(negedge clk);
    end
    start = 0; abort = 0;
  endtask

  initial begin
    int exp_rd[4];
    logic [7:0] first_byte;
    exp_rd = '{1, 67, 133, 199};
    foreach (mem[i]) mem[i] = 32'(i) * 32'h01010101;
    mem[0] = 32'hA5A50001; mem[1] = 32'h0F0F0002;
    mem[2] = 32'hFFFF0003; mem[3] = 32'h00000004;
    mem[8'hFE] = 32'h12345678; mem[8'hFF] = 32'h80000001;

    @(posedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(rd_en_b), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
`ifdef RIS_FRAME_XOR_EN
    chk("rst_frame_xor", frame_xor, 0);
`endif
    rst = 0;

    // full frame from base 0
    run(8'h00, 0, 0, 0);
    chk("done_cycle", 32'(done_n), 267);
    chk("done_count", 32'(done_cnt), 1);
    chk("latch_cycles", 32'(lat_n), 2);
    chk("rd_count", 32'(rd_q.size()), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      chk("rd_cycle", 32'(rd_q[i]), 32'(exp_rd[i]));
      chk("rd_addr", 32'(ad_q[i]), 32'(i));
    end
    chk("bit_count", 32'(bits.size()), 128);
    first_byte = '0;
    for (int i = 0; i < 8 && i < bits.size(); i++) first_byte[7-i] = bits[i];
    chk("first_byte", 32'(first_byte), 32'hA5);
    for (int i = 0; i < bits.size() && i < 128; i++)
      chk("bit_stream", 32'(bits[i]), 32'(mem[i / 32][31 - i % 32]));
`ifdef RIS_FRAME_XOR_EN
    chk("frame_xor", frame_xor, 32'h55550004);
`endif

    // start re-pulsed while busy is ignored
    run(8'h00, 10, 200, 0);
    chk("busy_start_done_cycle", 32'(done_n), 267);
    chk("busy_start_done_count", 32'(done_cnt), 1);

    // abort mid-frame
    run(8'h00, 0, 0, 40);
    chk("abort_done_count", 32'(done_cnt), 0);
    chk("abort_latch", 32'(lat_n), 0);
    chk("abort_busy", 32'(busy), 0);

    // start and abort together in idle: nothing starts
    @(negedge clk); start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_rd", 32'(rd_en_b), 0);

    run(8'h00, 0, 0, 0);
    chk("post_abort_done_cycle", 32'(done_n), 267);
    chk("post_abort_latch", 32'(lat_n), 2);

    // address wrap
    run(8'hFE, 0, 0, 0);
    chk("wrap_rd_count", 32'(ad_q.size()), 4);
    if (ad_q.size() == 4) begin
      chk("wrap_a0", 32'(ad_q[0]), 32'hFE);
      chk("wrap_a1", 32'(ad_q[1]), 32'hFF);
      chk("wrap_a2", 32'(ad_q[2]), 32'h00);
      chk("wrap_a3", 32'(ad_q[3]), 32'h01);
    end
    chk("wrap_done_cycle", 32'(done_n), 267);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
